// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants, S-box and Rcon tables, key-schedule FSM states.
package aes_pkg;

    localparam int AES_BLK_W  = 128;
    localparam int AES_WORD_W = 32;

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} ks_state_t;

    // Byte r of this table (counting from bit 0) is Rcon[r]; entry 0 and 11..15 are unused zeros
    localparam logic [127:0] RCON_TBL = 128'h00000000_00361b80_40201008_04020100;

    // Byte 0 of the S-box sits in the most significant byte
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        return RCON_TBL[{r, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/aes_key_schedule_seq_if.sv
// aes_key_schedule_seq_if: start/key request and round-key bank bus of the key scheduler.
interface aes_key_schedule_seq_if #(
    parameter int NR = 10
);
    logic [aes_pkg::AES_BLK_W-1:0]        key;
    logic                                 start;
    logic [(NR+1)*aes_pkg::AES_BLK_W-1:0] allKeys;
    logic                                 busy;
    logic                                 keys_valid;

    modport master (output key, start, input allKeys, busy, keys_valid);
    modport slave  (input key, start, output allKeys, busy, keys_valid);
endinterface

// File: rtl/aes_key_round.sv
// aes_key_round: one combinational AES-128 key-expansion step (4 S-box lookups).
module aes_key_round
    import aes_pkg::*;
(
    input  logic [AES_BLK_W-1:0] prev_key,
    input  logic [7:0]           rcon,
    output logic [AES_BLK_W-1:0] next_key
);
    logic [AES_WORD_W-1:0] t, w0, w1, w2, w3;

    // SubWord(RotWord(w3)) ^ Rcon
    assign t  = {sbox(prev_key[23:16]), sbox(prev_key[15:8]), sbox(prev_key[7:0]),
                 sbox(prev_key[31:24])} ^ {rcon, 24'h0};
    assign w0 = prev_key[127:96] ^ t;
    assign w1 = prev_key[95:64] ^ w0;
    assign w2 = prev_key[63:32] ^ w1;
    assign w3 = prev_key[31:0] ^ w2;
    assign next_key = {w0, w1, w2, w3};

endmodule

// File: rtl/aes_key_schedule_seq.sv
// aes_key_schedule_seq: iterative AES-128 key expansion, one round key per clock into a key bank.
// Define AES_KS_CACHE_EN to skip re-expansion when DONE is restarted with the last completed key.
module aes_key_schedule_seq
    import aes_pkg::*;
#(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input logic                   clk,
    input logic                   rst_n,
    aes_key_schedule_seq_if.slave ks
);
    localparam int KW = Nk * AES_WORD_W;

    ks_state_t                   state_q, state_d;
    logic [3:0]                  rnd_q, rnd_d, prv;
    logic [(Nr+1)*AES_BLK_W-1:0] bank_q, bank_d;
    logic                        busy_q, busy_d, valid_q, valid_d;
    logic [AES_BLK_W-1:0]        prev_key, next_key;
    logic                        hit, last_rnd;

    assign prv      = rnd_q - 4'd1;
    assign prev_key = bank_q[AES_BLK_W*int'(prv) +: AES_BLK_W];
    assign last_rnd = rnd_q == 4'(Nr);

    aes_key_round u_round (.prev_key(prev_key), .rcon(rcon(rnd_q)), .next_key(next_key));

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        bank_d  = bank_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        if (ks.start && state_q != EXPAND && !hit) begin
            state_d        = EXPAND;
            rnd_d          = 4'd1;
            bank_d[KW-1:0] = ks.key;
            busy_d         = 1'b1;
            valid_d        = 1'b0;
        end else if (state_q == EXPAND) begin
            bank_d[AES_BLK_W*int'(rnd_q) +: AES_BLK_W] = next_key;
            rnd_d = &rnd_q ? rnd_q : rnd_q + 4'd1;
            if (last_rnd) begin
                state_d = DONE;
                busy_d  = 1'b0;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rnd_q   <= '0;
            bank_q  <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            bank_q  <= bank_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

`ifdef AES_KS_CACHE_EN
    logic [AES_BLK_W-1:0] last_key_q, last_key_d;
    logic                 cache_vld_q, cache_vld_d;

    assign hit = state_q == DONE && cache_vld_q && ks.key == last_key_q;

    // Slot 0 still holds the key being expanded when the final round lands
    always_comb begin
        last_key_d  = last_key_q;
        cache_vld_d = cache_vld_q;
        if (state_q == EXPAND && last_rnd) begin
            last_key_d  = bank_q[AES_BLK_W-1:0];
            cache_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_key_q  <= '0;
            cache_vld_q <= 1'b0;
        end else begin
            last_key_q  <= last_key_d;
            cache_vld_q <= cache_vld_d;
        end
    end
`else
    assign hit = 1'b0;
`endif

    assign ks.allKeys    = bank_q;
    assign ks.busy       = busy_q;
    assign ks.keys_valid = valid_q;

endmodule
